pattern_sender: RTL and testbench

PATTERN_SENDER -- requirements
Module: pattern_sender

---
 rtl/pattern_sender.sv | 162 ++++++++++++++++
 tb/tb_pattern_sender.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sender.sv
`timescale 1ns/1ps
// pattern_sender
//
// Emits a stream of data items (data, qualified by en).
//  - Each item's data is the previous data plus step, wrapping modulo
//    2^DATA_W.
//  - Consecutive items are separated by a pseudo-random number of idle
//    cycles, drawn from [gap_from, gap_to].
//  - A run lasts num_items items (0 = unlimited).
//  - A run also ends after the current item once go drops.
//
// Optional feature: `define READY_HANDSHAKE_EN
//  - Defined: en behaves as a valid and is held until the sink asserts
//    ready.
//  - Undefined: ready is ignored, and every item is a single-cycle en
//    pulse.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   go         level run request; 0 stops after the current item
//   step       per-item data increment
//   num_items  items per run, 0 = unlimited
//   gap_from   minimum idle cycles between items
//   gap_to     maximum idle cycles between items
//   ready      sink accept (READY_HANDSHAKE_EN builds only)
//   data       current item
//   en         item valid strobe
//   busy       high whenever the sender is not idle
//   sent_cnt   items accepted since reset (wraps)
//   done       one-cycle pulse when a run reaches num_items
module pattern_sender #(
  parameter int          DATA_W = 4,
  parameter int          GAP_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] step,
  input  logic [15:0]       num_items,
  input  logic [GAP_W-1:0]  gap_from,
  input  logic [GAP_W-1:0]  gap_to,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              en,
  output logic              busy,
  output logic [15:0]       sent_cnt,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state;
  logic [15:0]       run_cnt;
  logic [15:0]       run_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_g;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic              accept;

  // Gap length for the item being accepted.
  //  - An inverted range collapses to its lower bound.
  //  - Otherwise the LFSR bits are reduced modulo the span.
  //  - The span is computed one bit wider, so that a full-range span of
  //    2^GAP_W does not overflow.
  function automatic logic [GAP_W-1:0] calc_gap(
    input logic [GAP_W-1:0] lo,
    input logic [GAP_W-1:0] hi,
    input logic [15:0]      rnd
  );
    logic [GAP_W:0] span;
    logic [GAP_W:0] offs;
    if (hi < lo) begin
      calc_gap = lo;
    end else begin
      span     = {1'b0, hi} - {1'b0, lo} + (GAP_W+1)'(1);
      offs     = {1'b0, rnd[GAP_W-1:0]} % span;
      calc_gap = lo + offs[GAP_W-1:0];
    end
  endfunction

  // Galois LFSR, taps 16'hB400.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign gap_g     = calc_gap(gap_from, gap_to, lfsr);
  assign run_next  = run_cnt + 16'd1;

`ifdef READY_HANDSHAKE_EN
  assign accept = (state == SEND) && ready;
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign accept       = (state == SEND);
`endif

  // en and busy decode directly from the registered state.
  assign en   = (state == SEND);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data     <= '0;
      done     <= 1'b0;
      sent_cnt <= '0;
      run_cnt  <= '0;
      gap_cnt  <= '0;
      lfsr     <= SEED;
    end else begin
      lfsr <= lfsr_next;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state <= SEND;
            data  <= data + step;
          end
        end
        SEND: begin
          if (accept) begin
            sent_cnt <= sent_cnt + 16'd1;
            gap_cnt  <= gap_g;
            // Reaching the item limit takes priority over go: the run
            // ends with done even if go is still high.
            if ((num_items != 16'd0) && (run_next == num_items)) begin
              state   <= IDLE;
              done    <= 1'b1;
              run_cnt <= '0;
            end else begin
              run_cnt <= run_next;
              if (!go) begin
                state <= IDLE;
              end else if (gap_g == '0) begin
                data <= data + step;
              end else begin
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          // gap_cnt was loaded with G >= 1; leaving on the count of 1
          // makes GAP last exactly G cycles.
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            if (go) begin
              state <= SEND;
              data  <= data + step;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sender.sv
`timescale 1ns/1ps
// Testbench for pattern_sender
//  - Directed scenarios run in one initial block, with randomized step
//    values.
//  - Gap lengths are checked against a reference model.
//  - The model derives each gap from the gap rule, using an LFSR that
//    tracks cycles since reset.
module tb_pattern_sender;

  localparam int          DATA_W = 4;
  localparam int          GAP_W  = 8;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic [DATA_W-1:0] step = '0;
  logic [15:0]       num_items = '0;
  logic [GAP_W-1:0]  gap_from = '0;
  logic [GAP_W-1:0]  gap_to = '0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] data;
  logic              en;
  logic              busy;
  logic [15:0]       sent_cnt;
  logic              done;

  always #5 clk = ~clk;

  pattern_sender #(.DATA_W(DATA_W), .GAP_W(GAP_W), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .go(go), .step(step), .num_items(num_items),
    .gap_from(gap_from), .gap_to(gap_to), .ready(ready),
    .data(data), .en(en), .busy(busy), .sent_cnt(sent_cnt), .done(done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference pseudo-random source.
  //  - Reloaded with SEED during reset.
  //  - Otherwise advances once per cycle.
  logic [15:0] ref_lfsr;
  always @(posedge clk) begin
    if (rst) ref_lfsr <= SEED;
    else     ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Idle cycles expected after an item accepted while the random source
  // holds r.
  function automatic int model_gap(input int lo, input int hi, input logic [15:0] r);
    if (hi < lo) return lo;
    return lo + ((int'(r) & ((1 << GAP_W) - 1)) % (hi - lo + 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sent"}, 32'(sent_cnt), 0);
    chk({tag, "_lfsr"}, 32'(dut.lfsr), 32'(SEED));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cyc_q[$];
  int dat_q[$];

  // Gather up to n items. go drops during the last one, so the run
  // stops after it.
  task automatic collect(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    cyc_q.delete();
    dat_q.delete();
    while (dat_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (en === 1'b1) begin
        cyc_q.push_back(cyc);
        dat_q.push_back(int'(data));
        if (dat_q.size() == n) go = 1'b0;
      end
    end
    chk({tag, "_count"}, 32'(dat_q.size()), 32'(n));
  endtask

  int                items;
  int                cyc;
  int                prev;
  int                exp_gap;
  int                obs_gap;
  int                step_r;
  bit                seen[0:31];
  logic [DATA_W-1:0] exp_d;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    do_reset();
    chk_reset_vals("reset");

    // Back-to-back run of 5 items, step 1
    step = 4'd1; gap_from = 0; gap_to = 0; num_items = 16'd5; go = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("b2b_en", 32'(en), 1);
      chk("b2b_data", 32'(data), 32'(i));
      chk("b2b_sent", 32'(sent_cnt), 32'(i - 1));
    end
    @(negedge clk);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_busy", 32'(busy), 0);
    chk("b2b_en_off", 32'(en), 0);
    chk("b2b_sent_final", 32'(sent_cnt), 5);
    go = 1'b0;
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 0);
    chk("b2b_stay_idle", 32'(busy), 0);

    // Fixed gap of 3, step 2
    do_reset();
    step = 4'd2; gap_from = 8'd3; gap_to = 8'd3; num_items = 0; go = 1'b1;
    collect(4, 50, "gap3");
    for (int k = 0; k < dat_q.size(); k++) begin
      chk("gap3_data", 32'(dat_q[k]), 32'((2 * (k + 1)) % 16));
      if (k > 0) chk("gap3_spacing", 32'(cyc_q[k] - cyc_q[k-1] - 1), 3);
    end
    @(negedge clk);
    chk("gap3_stop_busy", 32'(busy), 0);
    chk("gap3_no_done", 32'(done), 0);

    // Wrapping data, unlimited run, stopped by go
    do_reset();
    step = 4'd5; gap_from = 0; gap_to = 0; num_items = 0; go = 1'b1;
    collect(5, 20, "wrap");
    for (int k = 0; k < dat_q.size(); k++) begin
      chk("wrap_data", 32'(dat_q[k]), 32'((5 * (k + 1)) % 16));
      if (k > 0) chk("wrap_spacing", 32'(cyc_q[k] - cyc_q[k-1]), 1);
    end
    @(negedge clk);
    chk("wrap_idle", 32'(busy), 0);
    chk("wrap_no_done", 32'(done), 0);
    chk("wrap_sent", 32'(sent_cnt), 5);

    // Random gaps in [2,6], 1000 items, random step
    do_reset();
    step_r = int'($urandom_range(1, 15));
    step = DATA_W'(step_r); gap_from = 8'd2; gap_to = 8'd6; num_items = 16'd1000; go = 1'b1;
    items = 0; cyc = 0; prev = 0; exp_gap = 0; exp_d = '0;
    for (int v = 0; v < 32; v++) seen[v] = 1'b0;
    while (items < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (en === 1'b1) begin
        exp_d = exp_d + DATA_W'(step_r);
        chk("rand_data", 32'(data), 32'(exp_d));
        if (items > 0) begin
          obs_gap = cyc - prev - 1;
          chk("rand_gap", 32'(obs_gap), 32'(exp_gap));
          chk("rand_gap_range", 32'(obs_gap >= 2 && obs_gap <= 6), 1);
          if (obs_gap >= 0 && obs_gap < 32) seen[obs_gap] = 1'b1;
        end
        exp_gap = model_gap(2, 6, ref_lfsr);
        prev = cyc;
        items++;
      end
    end
    chk("rand_items", 32'(items), 1000);
    @(negedge clk);
    chk("rand_done", 32'(done), 1);
    chk("rand_busy", 32'(busy), 0);
    chk("rand_sent", 32'(sent_cnt), 1000);
    go = 1'b0;
    for (int v = 2; v <= 6; v++) chk("rand_gap_seen", 32'(seen[v]), 1);

    // Inverted range: every gap equals gap_from
    do_reset();
    step = 4'd1; gap_from = 8'd6; gap_to = 8'd2; num_items = 16'd20; go = 1'b1;
    items = 0; cyc = 0; prev = 0;
    while (items < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (en === 1'b1) begin
        if (items > 0) chk("inv_gap", 32'(cyc - prev - 1), 6);
        prev = cyc;
        items++;
      end
    end
    chk("inv_items", 32'(items), 20);
    @(negedge clk);
    chk("inv_done", 32'(done), 1);
    go = 1'b0;

`ifdef READY_HANDSHAKE_EN
    // ready held low for 4 cycles: en stays up and data holds
    do_reset();
    step = 4'd3; gap_from = 0; gap_to = 0; num_items = 0; ready = 1'b0; go = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("hs_en_held", 32'(en), 1);
      chk("hs_data_stable", 32'(data), 3);
      chk("hs_sent_wait", 32'(sent_cnt), 0);
      if (i == 5) begin
        ready = 1'b1;
        go = 1'b0;
      end
    end
    @(negedge clk);
    chk("hs_en_off", 32'(en), 0);
    chk("hs_sent_one", 32'(sent_cnt), 1);
    chk("hs_idle", 32'(busy), 0);
    ready = 1'b0;
`else
    // ready ignored: single-cycle items despite ready low
    do_reset();
    step = 4'd3; gap_from = 0; gap_to = 0; num_items = 16'd3; ready = 1'b0; go = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("nohs_en", 32'(en), 1);
      chk("nohs_data", 32'(data), 32'(3 * i));
      chk("nohs_sent", 32'(sent_cnt), 32'(i - 1));
    end
    @(negedge clk);
    chk("nohs_done", 32'(done), 1);
    chk("nohs_sent_final", 32'(sent_cnt), 3);
    go = 1'b0;
`endif

    // Reset asserted mid-GAP, then mid-SEND
    do_reset();
    step = 4'd1; gap_from = 8'd3; gap_to = 8'd3; num_items = 0; go = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (en !== 1'b1 && cyc < 10);
    chk("rstgap_first_en", 32'(en), 1);
    @(negedge clk);
    chk("rstgap_in_gap", 32'(busy && !en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid_gap");
    rst = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (en !== 1'b1 && cyc < 10);
    chk("rstsend_en", 32'(en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid_send");
    rst = 1'b0;
    go = 1'b0;
    @(negedge clk);
    chk("rst_after_idle", 32'(busy), 0);
    chk("rst_after_no_done", 32'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
